// File: rtl/load_store_sequencer_if.sv
// Data-memory bus between the load/store sequencer (master) and the memory side (slave).
// Word-aligned request with a single ready handshake that also returns read data.
interface load_store_sequencer_if #(
  parameter int unsigned ADDR_WIDTH = 32
);
  logic                  bus_req;
  logic                  bus_we;
  logic [ADDR_WIDTH-1:0] bus_addr;
  logic [3:0]            bus_wstrb;
  logic [31:0]           bus_wdata;
  logic                  bus_ready;
  logic [31:0]           bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_wstrb, bus_wdata,
    input  bus_ready, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_wstrb, bus_wdata,
    output bus_ready, bus_rdata
  );
endinterface

// File: rtl/load_store_sequencer.sv
// Load/store sequencer: runs one word-aligned data-memory transaction per decoded
// load/store, stalls the pipeline meanwhile and returns extended load data.
module load_store_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned ADDR_WIDTH     = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_start,
  input  logic                  i_mem_read,
  input  logic                  i_mem_write,
  input  logic [1:0]            i_mem_size,
  input  logic                  i_mem_unsigned,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [31:0]           i_store_data,
  input  logic [4:0]            i_rd_addr,
  output logic                  o_stall,
  output logic                  o_done,
  output logic [31:0]           o_load_data,
  output logic                  o_wb_en,
  output logic [4:0]            o_wb_rd_addr,
  output logic                  o_misaligned,
  output logic                  o_bus_error,
  load_store_sequencer_if.master bus
);

  localparam int unsigned CNT_W = 16;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_FAULT  = 2'd2;

  // FSM state and latched operation
  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_is_load;
  logic [1:0]       r_size;
  logic             r_unsigned;
  logic [1:0]       r_off;
  logic [4:0]       r_rd;

  // Registered outputs
  logic                  r_done;
  logic [31:0]           r_load_data;
  logic                  r_wb_en;
  logic [4:0]            r_wb_rd_addr;
  logic                  r_misaligned;
  logic                  r_bus_error;
  logic                  r_bus_req;
  logic                  r_bus_we;
  logic [ADDR_WIDTH-1:0] r_bus_addr;
  logic [3:0]            r_bus_wstrb;
  logic [31:0]           r_bus_wdata;

  // Next-state values
  logic [1:0]            w_state_nxt;
  logic [CNT_W-1:0]      w_cnt_nxt;
  logic                  w_is_load_nxt;
  logic [1:0]            w_size_nxt;
  logic                  w_unsigned_nxt;
  logic [1:0]            w_off_nxt;
  logic [4:0]            w_rd_nxt;
  logic                  w_done_nxt;
  logic [31:0]           w_load_data_nxt;
  logic                  w_wb_en_nxt;
  logic [4:0]            w_wb_rd_addr_nxt;
  logic                  w_misaligned_nxt;
  logic                  w_bus_error_nxt;
  logic                  w_bus_req_nxt;
  logic                  w_bus_we_nxt;
  logic [ADDR_WIDTH-1:0] w_bus_addr_nxt;
  logic [3:0]            w_bus_wstrb_nxt;
  logic [31:0]           w_bus_wdata_nxt;

  logic        w_valid_op;
  logic        w_misalign;
  logic [3:0]  w_lane_strb;
  logic [31:0] w_lane_data;
  logic [7:0]  w_rbyte;
  logic [15:0] w_rhalf;
  logic [31:0] w_rext;

  assign w_valid_op = i_start & (i_mem_read | i_mem_write);
  assign w_misalign = (i_mem_size == 2'd3)
                    | ((i_mem_size == SZ_HALF) & i_addr[0])
                    | ((i_mem_size == SZ_WORD) & (i_addr[1:0] != 2'b00));

  assign o_stall = ((r_state == S_IDLE) & w_valid_op) | (r_state != S_IDLE);

  // Store lane replication and byte enables from the incoming op
  always_comb begin
    w_lane_strb = 4'b1111;
    w_lane_data = i_store_data;
    case (i_mem_size)
      SZ_BYTE: begin
        w_lane_strb = 4'b0001 << i_addr[1:0];
        w_lane_data = {4{i_store_data[7:0]}};
      end
      SZ_HALF: begin
        w_lane_strb = 4'b0011 << {i_addr[1], 1'b0};
        w_lane_data = {2{i_store_data[15:0]}};
      end
      default: ;
    endcase
  end

  // Load lane extraction and sign/zero extension from the latched op
  always_comb begin
    w_rbyte = bus.bus_rdata[{r_off, 3'b000} +: 8];
    w_rhalf = bus.bus_rdata[{r_off[1], 4'b0000} +: 16];
    w_rext  = bus.bus_rdata;
    case (r_size)
      SZ_BYTE: w_rext = r_unsigned ? {24'd0, w_rbyte} : {{24{w_rbyte[7]}}, w_rbyte};
      SZ_HALF: w_rext = r_unsigned ? {16'd0, w_rhalf} : {{16{w_rhalf[15]}}, w_rhalf};
      default: ;
    endcase
  end

  // Next-state and next-output logic
  always_comb begin
    w_state_nxt      = r_state;
    w_cnt_nxt        = r_cnt;
    w_is_load_nxt    = r_is_load;
    w_size_nxt       = r_size;
    w_unsigned_nxt   = r_unsigned;
    w_off_nxt        = r_off;
    w_rd_nxt         = r_rd;
    w_done_nxt       = 1'b0;
    w_load_data_nxt  = 32'd0;
    w_wb_en_nxt      = 1'b0;
    w_wb_rd_addr_nxt = 5'd0;
    w_misaligned_nxt = 1'b0;
    w_bus_error_nxt  = 1'b0;
    w_bus_req_nxt    = r_bus_req;
    w_bus_we_nxt     = r_bus_we;
    w_bus_addr_nxt   = r_bus_addr;
    w_bus_wstrb_nxt  = r_bus_wstrb;
    w_bus_wdata_nxt  = r_bus_wdata;

    case (r_state)
      S_IDLE: begin
        if (w_valid_op) begin
          w_is_load_nxt  = ~i_mem_write;
          w_size_nxt     = i_mem_size;
          w_unsigned_nxt = i_mem_unsigned;
          w_off_nxt      = i_addr[1:0];
          w_rd_nxt       = i_rd_addr;
          w_cnt_nxt      = '0;
          if (w_misalign) begin
            w_state_nxt = S_FAULT;
          end else begin
            w_state_nxt     = S_ACCESS;
            w_bus_req_nxt   = 1'b1;
            w_bus_we_nxt    = i_mem_write;
            w_bus_addr_nxt  = {i_addr[ADDR_WIDTH-1:2], 2'b00};
            w_bus_wstrb_nxt = i_mem_write ? w_lane_strb : 4'b0000;
            w_bus_wdata_nxt = i_mem_write ? w_lane_data : 32'd0;
          end
        end
      end
      S_ACCESS: begin
        if (bus.bus_ready || (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1))) begin
          w_state_nxt      = S_IDLE;
          w_done_nxt       = 1'b1;
          w_wb_rd_addr_nxt = r_rd;
          w_bus_req_nxt    = 1'b0;
          w_bus_we_nxt     = 1'b0;
          w_bus_addr_nxt   = '0;
          w_bus_wstrb_nxt  = 4'b0000;
          w_bus_wdata_nxt  = 32'd0;
          // A ready in the final allowed cycle still completes normally
          if (bus.bus_ready) begin
            w_load_data_nxt = r_is_load ? w_rext : 32'd0;
            w_wb_en_nxt     = r_is_load & (r_rd != 5'd0);
          end else begin
            w_bus_error_nxt = 1'b1;
          end
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      S_FAULT: begin
        w_state_nxt      = S_IDLE;
        w_done_nxt       = 1'b1;
        w_misaligned_nxt = 1'b1;
        w_wb_rd_addr_nxt = r_rd;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_is_load    <= 1'b0;
      r_size       <= 2'd0;
      r_unsigned   <= 1'b0;
      r_off        <= 2'd0;
      r_rd         <= 5'd0;
      r_done       <= 1'b0;
      r_load_data  <= 32'd0;
      r_wb_en      <= 1'b0;
      r_wb_rd_addr <= 5'd0;
      r_misaligned <= 1'b0;
      r_bus_error  <= 1'b0;
      r_bus_req    <= 1'b0;
      r_bus_we     <= 1'b0;
      r_bus_addr   <= '0;
      r_bus_wstrb  <= 4'b0000;
      r_bus_wdata  <= 32'd0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_is_load    <= w_is_load_nxt;
      r_size       <= w_size_nxt;
      r_unsigned   <= w_unsigned_nxt;
      r_off        <= w_off_nxt;
      r_rd         <= w_rd_nxt;
      r_done       <= w_done_nxt;
      r_load_data  <= w_load_data_nxt;
      r_wb_en      <= w_wb_en_nxt;
      r_wb_rd_addr <= w_wb_rd_addr_nxt;
      r_misaligned <= w_misaligned_nxt;
      r_bus_error  <= w_bus_error_nxt;
      r_bus_req    <= w_bus_req_nxt;
      r_bus_we     <= w_bus_we_nxt;
      r_bus_addr   <= w_bus_addr_nxt;
      r_bus_wstrb  <= w_bus_wstrb_nxt;
      r_bus_wdata  <= w_bus_wdata_nxt;
    end
  end

  assign o_done         = r_done;
  assign o_load_data    = r_load_data;
  assign o_wb_en        = r_wb_en;
  assign o_wb_rd_addr   = r_wb_rd_addr;
  assign o_misaligned   = r_misaligned;
  assign o_bus_error    = r_bus_error;
  assign bus.bus_req    = r_bus_req;
  assign bus.bus_we     = r_bus_we;
  assign bus.bus_addr   = r_bus_addr;
  assign bus.bus_wstrb  = r_bus_wstrb;
  assign bus.bus_wdata  = r_bus_wdata;

endmodule

// File: tb/tb_load_store_sequencer.sv
// Scoreboard bench for load_store_sequencer: stimulus pushes expected completions,
// a negedge monitor pops and compares them whenever done is presented.
module tb_load_store_sequencer;

  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_start, i_mem_read, i_mem_write, i_mem_unsigned;
  logic [1:0]  i_mem_size;
  logic [31:0] i_addr, i_store_data;
  logic [4:0]  i_rd_addr;
  logic        o_stall, o_done, o_wb_en, o_misaligned, o_bus_error;
  logic [31:0] o_load_data;
  logic [4:0]  o_wb_rd_addr;

  load_store_sequencer_if #(.ADDR_WIDTH(32)) bus_if ();

  load_store_sequencer #(.TIMEOUT_CYCLES(TO), .ADDR_WIDTH(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .i_start        (i_start),
    .i_mem_read     (i_mem_read),
    .i_mem_write    (i_mem_write),
    .i_mem_size     (i_mem_size),
    .i_mem_unsigned (i_mem_unsigned),
    .i_addr         (i_addr),
    .i_store_data   (i_store_data),
    .i_rd_addr      (i_rd_addr),
    .o_stall        (o_stall),
    .o_done         (o_done),
    .o_load_data    (o_load_data),
    .o_wb_en        (o_wb_en),
    .o_wb_rd_addr   (o_wb_rd_addr),
    .o_misaligned   (o_misaligned),
    .o_bus_error    (o_bus_error),
    .bus            (bus_if.master)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] ld;
    logic        wb_en;
    logic [4:0]  rd;
    logic        chk_rd;
    logic        mis;
    logic        berr;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_chk = 0;
  int   n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] ld, input logic wb, input logic [4:0] rd,
                              input logic chk_rd, input logic mis, input logic berr);
    exp_t e;
    e.ld = ld; e.wb_en = wb; e.rd = rd; e.chk_rd = chk_rd; e.mis = mis; e.berr = berr;
    return e;
  endfunction

  // Monitor: every done must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (!rst && o_done) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_done", 32'(o_done), 32'd0);
      end else begin
        mon_e = sb_q.pop_front();
        chk("load_data", o_load_data, mon_e.ld);
        chk("wb_en", 32'(o_wb_en), 32'(mon_e.wb_en));
        if (mon_e.chk_rd) chk("wb_rd_addr", 32'(o_wb_rd_addr), 32'(mon_e.rd));
        chk("misaligned", 32'(o_misaligned), 32'(mon_e.mis));
        chk("bus_error", 32'(o_bus_error), 32'(mon_e.berr));
      end
    end
  end

  task automatic clr_inputs();
    i_start = 1'b0; i_mem_read = 1'b0; i_mem_write = 1'b0; i_mem_size = 2'd0;
    i_mem_unsigned = 1'b0; i_addr = 32'd0; i_store_data = 32'd0; i_rd_addr = 5'd0;
  endtask

  // Called at posedge+1; returns at posedge+1 of the done cycle
  task automatic run_op(input logic rd_i, input logic wr_i, input logic [1:0] sz, input logic uns,
                        input logic [31:0] a, input logic [31:0] sd, input logic [4:0] rda,
                        input int delay, input logic give_ready, input logic [31:0] rdata,
                        input exp_t e, input logic exp_req, input logic [3:0] exp_strb,
                        input logic [31:0] exp_wdata);
    int n;
    sb_q.push_back(e);
    i_start = 1'b1; i_mem_read = rd_i; i_mem_write = wr_i; i_mem_size = sz;
    i_mem_unsigned = uns; i_addr = a; i_store_data = sd; i_rd_addr = rda;
    #1 chk("stall_on_start", 32'(o_stall), 32'd1);
    @(posedge clk); #1;
    clr_inputs();
    n = delay + (give_ready ? 1 : 0);
    for (int i = 0; i < n; i++) begin
      chk("stall_busy", 32'(o_stall), 32'd1);
      chk("bus_req", 32'(bus_if.bus_req), 32'(exp_req));
      if (exp_req) begin
        chk("bus_addr", bus_if.bus_addr, {a[31:2], 2'b00});
        chk("bus_we", 32'(bus_if.bus_we), 32'(wr_i));
        chk("bus_wstrb", 32'(bus_if.bus_wstrb), 32'(exp_strb));
        if (wr_i) chk("bus_wdata", bus_if.bus_wdata, exp_wdata);
      end
      if (give_ready && i == n - 1) begin
        bus_if.bus_ready = 1'b1;
        bus_if.bus_rdata = rdata;
      end
      @(posedge clk); #1;
      bus_if.bus_ready = 1'b0;
      bus_if.bus_rdata = 32'd0;
    end
    chk("done_latency", 32'(o_done), 32'd1);
    chk("stall_in_done", 32'(o_stall), 32'd0);
    chk("bus_req_dropped", 32'(bus_if.bus_req), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    clr_inputs();
    bus_if.bus_ready = 1'b0;
    bus_if.bus_rdata = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_done", 32'(o_done), 32'd0);
    chk("rst_load_data", o_load_data, 32'd0);
    chk("rst_wb", {26'd0, o_wb_en, o_wb_rd_addr}, 32'd0);
    chk("rst_flags", {30'd0, o_misaligned, o_bus_error}, 32'd0);
    chk("rst_bus_ctl", {27'd0, bus_if.bus_req, bus_if.bus_we, bus_if.bus_wstrb[2:0]}, 32'd0);
    chk("rst_bus_wstrb3", 32'(bus_if.bus_wstrb[3]), 32'd0);
    chk("rst_bus_addr", bus_if.bus_addr, 32'd0);
    chk("rst_bus_wdata", bus_if.bus_wdata, 32'd0);
    chk("rst_stall", 32'(o_stall), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // LB sign-extended, immediate ready
    run_op(1, 0, 2'd0, 0, 32'h1003, 32'h0, 5'd5, 0, 1, 32'h80AABBCC,
           mk(32'hFFFFFF80, 1, 5'd5, 1, 0, 0), 1, 4'b0000, 32'h0);
    // SH upper half, ready after 3 wait cycles (back-to-back with previous done)
    run_op(0, 1, 2'd1, 0, 32'h2002, 32'h1234ABCD, 5'd0, 3, 1, 32'h0,
           mk(32'h0, 0, 5'd0, 0, 0, 0), 1, 4'b1100, 32'hABCDABCD);
    // LW misaligned
    run_op(1, 0, 2'd2, 0, 32'h3001, 32'h0, 5'd3, 1, 0, 32'h0,
           mk(32'h0, 0, 5'd3, 0, 1, 0), 0, 4'b0000, 32'h0);
    // Illegal size at an aligned address
    run_op(1, 0, 2'd3, 0, 32'h5000, 32'h0, 5'd6, 1, 0, 32'h0,
           mk(32'h0, 0, 5'd6, 0, 1, 0), 0, 4'b0000, 32'h0);
    // LHU to x0
    run_op(1, 0, 2'd1, 1, 32'h4002, 32'h0, 5'd0, 0, 1, 32'hF00D0000,
           mk(32'h0000F00D, 0, 5'd0, 1, 0, 0), 1, 4'b0000, 32'h0);
    // LH sign-extended upper half
    run_op(1, 0, 2'd1, 0, 32'h7002, 32'h0, 5'd10, 1, 1, 32'h80011234,
           mk(32'hFFFF8001, 1, 5'd10, 1, 0, 0), 1, 4'b0000, 32'h0);
    // SB lane 1
    run_op(0, 1, 2'd0, 0, 32'h8001, 32'h000000A5, 5'd0, 2, 1, 32'h0,
           mk(32'h0, 0, 5'd0, 0, 0, 0), 1, 4'b0010, 32'hA5A5A5A5);
    // read and write both set behaves as a store
    run_op(1, 1, 2'd2, 0, 32'h9000, 32'hDEADBEEF, 5'd7, 0, 1, 32'h12345678,
           mk(32'h0, 0, 5'd0, 0, 0, 0), 1, 4'b1111, 32'hDEADBEEF);
    // LBU lane 2
    run_op(1, 0, 2'd0, 1, 32'hA002, 32'h0, 5'd1, 0, 1, 32'h00F70000,
           mk(32'h000000F7, 1, 5'd1, 1, 0, 0), 1, 4'b0000, 32'h0);
    // Bus timeout after TO access cycles
    run_op(1, 0, 2'd2, 0, 32'h6000, 32'h0, 5'd9, int'(TO), 0, 32'h0,
           mk(32'h0, 0, 5'd9, 0, 0, 1), 1, 4'b0000, 32'h0);
    // Accepted back-to-back in the timeout done cycle
    run_op(1, 0, 2'd2, 0, 32'hC004, 32'h0, 5'd31, 0, 1, 32'h11223344,
           mk(32'h11223344, 1, 5'd31, 1, 0, 0), 1, 4'b0000, 32'h0);

    // start with neither read nor write is ignored
    i_start = 1'b1;
    #1 chk("nop_stall", 32'(o_stall), 32'd0);
    @(posedge clk); #1;
    i_start = 1'b0;
    chk("nop_no_req", 32'(bus_if.bus_req), 32'd0);
    @(posedge clk); #1;
    chk("nop_no_done", 32'(o_done), 32'd0);

    // Reset in the middle of an access
    i_start = 1'b1; i_mem_read = 1'b1; i_mem_size = 2'd2; i_addr = 32'hB000; i_rd_addr = 5'd4;
    @(posedge clk); #1;
    clr_inputs();
    chk("pre_rst_req", 32'(bus_if.bus_req), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_req", 32'(bus_if.bus_req), 32'd0);
    chk("midrst_stall", 32'(o_stall), 32'd0);
    chk("midrst_done", 32'(o_done), 32'd0);
    chk("midrst_bus_addr", bus_if.bus_addr, 32'd0);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 chk("midrst_no_late_done", 32'(o_done), 32'd0);

    // Normal operation after reset
    run_op(1, 0, 2'd2, 0, 32'hD000, 32'h0, 5'd2, 0, 1, 32'hCAFEF00D,
           mk(32'hCAFEF00D, 1, 5'd2, 1, 0, 0), 1, 4'b0000, 32'h0);

    repeat (3) @(posedge clk);
    #1 chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/load_store_sequencer.md
Name: load_store_sequencer

Overview:
- Multi-cycle controller between the decode/execute stage and the data-memory bus.
- Accepts one decoded load/store (mem_read, mem_write, mem_size, mem_unsigned) plus the ALU-computed effective address.
- Sequences a single word-aligned bus transaction with a req/ready handshake, stalls the pipeline while it runs, then returns sign/zero-extended load data for writeback.
- Detects misaligned accesses and bus timeouts.

Parameters:
- TIMEOUT_CYCLES, 255, max cycles bus_req may wait for bus_ready before the access is aborted (1..65535).
- ADDR_WIDTH, 32, width of effective address and bus address.

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  a decoded instruction is presented this cycle
- mem_read  in  1  instruction is a load
- mem_write  in  1  instruction is a store
- mem_size  in  2  0=byte, 1=half, 2=word, 3=illegal
- mem_unsigned  in  1  zero-extend load (LBU/LHU)
- addr  in  ADDR_WIDTH  effective address
- store_data  in  32  rs2 value
- rd_addr  in  5  load destination
- stall  out  1  pipeline must hold (combinational)
- done  out  1  one-cycle completion pulse
- load_data  out  32  extended load result, valid with done
- wb_en  out  1  register writeback strobe, valid with done
- wb_rd_addr  out  5  writeback destination, valid with done
- misaligned  out  1  fault flag, valid with done
- bus_error  out  1  timeout flag, valid with done
- bus_req  out  1  bus request
- bus_we  out  1  write request
- bus_addr  out  ADDR_WIDTH  word address, bits [1:0] forced 0
- bus_wstrb  out  4  byte enables, 0 on reads
- bus_wdata  out  32  lane-replicated store data
- bus_ready  in  1  bus accepts/completes this cycle
- bus_rdata  in  32  read data, valid when bus_ready=1

Behaviour:
- Clock is clk. Reset is rst, synchronous and active-high. On reset: state=IDLE, timeout counter=0, and every registered output is 0 (done, load_data, wb_en, wb_rd_addr, misaligned, bus_error, bus_req, bus_we, bus_addr, bus_wstrb, bus_wdata).
- A valid op is start & (mem_read | mem_write). start without either is ignored: no stall, no done.
- States: IDLE, ACCESS, FAULT.
- IDLE, valid op, aligned:
  - Latch op, rd_addr, addr[1:0] and size; drive the bus registers; go to ACCESS.
  - bus_req=1 from the next cycle.
- IDLE, valid op, misaligned (half with addr[0]=1; word with addr[1:0]!=0; size=3):
  - Go to FAULT; no bus_req is ever raised.
- ACCESS:
  - bus_req, bus_we, bus_addr, bus_wstrb and bus_wdata are held stable until bus_ready=1 is sampled.
  - On that edge: capture the extended load data, pulse done next cycle, bus_req=0 next cycle, return to IDLE.
  - The counter increments each cycle in ACCESS without bus_ready. When it reaches TIMEOUT_CYCLES: bus_req drops, done=1 and bus_error=1 next cycle, state returns to IDLE.
- FAULT: lasts one cycle, then done=1 and misaligned=1 next cycle; return to IDLE.
- stall = (IDLE & valid op) | ACCESS | FAULT. stall=0 in the done cycle.
  - A new start may be accepted in the same cycle done=1, since state is IDLE.
  - start is ignored while state != IDLE.
- Minimum latency is 2 cycles (start edge to done) when bus_ready is already high in the first ACCESS cycle.
- Store lanes:
  - Byte: bus_wdata = {4{sd[7:0]}}, bus_wstrb = 0001<<addr[1:0].
  - Half: bus_wdata = {2{sd[15:0]}}, bus_wstrb = 0011<<(2*addr[1]).
  - Word: bus_wdata = sd, bus_wstrb = 1111.
- Load extract:
  - Byte from rdata[8*addr[1:0] +: 8]; half from rdata[16*addr[1] +: 16]; word as-is.
  - Sign-extend unless mem_unsigned.
- wb_en = done & latched load & ~misaligned & ~bus_error & (wb_rd_addr != 0).
- load_data=0 on stores and on faults.
- done, wb_en, misaligned and bus_error are single-cycle pulses; all are 0 otherwise.
- If mem_read and mem_write are both 1, the op is treated as a store.
- Reset mid-ACCESS: bus_req=0 on the next edge; no done is produced for the aborted access.

Test Plan:
- LB addr=0x1003, bus_ready=1 immediately, rdata=0x80AABBCC -> bus_addr=0x1000, bus_wstrb=0, done 2 cycles after start, load_data=0xFFFFFF80, wb_en=1 with rd=5.
- SH addr=0x2002, sd=0x1234ABCD, bus_ready delayed 3 cycles -> bus_wdata=0xABCDABCD, bus_wstrb=1100 held stable 4 cycles, stall high throughout, done after ready, wb_en=0.
- LW addr=0x3001 -> bus_req never asserts, done+misaligned 2 cycles after start, wb_en=0; same result for mem_size=3 at any address.
- LHU addr=0x4002 rd=0, rdata=0xF00D0000 -> load_data=0x0000F00D, wb_en=0 because rd=x0.
- TIMEOUT_CYCLES=4, bus_ready held 0 -> bus_req drops after 4 ACCESS cycles, done+bus_error pulse, next start accepted.
- rst asserted during ACCESS -> bus_req=0 and all outputs 0 on the next edge; no done; a back-to-back start in the done cycle is accepted.
